sonar_ranger: RTL and testbench

- HC-SR04 ranging controller inside the VFD top. Drives s1_trig and times the s1_echo pulse returned by the sensor, or by the hc_sr04 model in simulation.
- Converts echo width into whole centimetres and presents one registered distance sample per measurement cycle to the display/UART logic downstream.
- Runs on the 1 MHz clock, so 1 tick = 1 us.

---
 rtl/sonar_ranger_if.sv | 31 +++
 rtl/sonar_ranger.sv | 223 ++++++++++++++++++++++
 tb/tb_sonar_ranger.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sonar_ranger_if.sv
// sonar_ranger_if: sensor pins and result bus of the HC-SR04 ranging controller.
// The ranger owns the master side; the sensor/downstream logic sits on slave.
interface sonar_ranger_if;
    logic       en;
    logic       s1_echo;
    logic       s1_trig;
    logic [9:0] dist_cm;
    logic       dist_vld;
    logic       timeout;
    logic       busy;

    modport master (
        input  en,
        input  s1_echo,
        output s1_trig,
        output dist_cm,
        output dist_vld,
        output timeout,
        output busy
    );

    modport slave (
        output en,
        output s1_echo,
        input  s1_trig,
        input  dist_cm,
        input  dist_vld,
        input  timeout,
        input  busy
    );
endinterface

// File: rtl/sonar_ranger.sv
// sonar_ranger: HC-SR04 ranging controller running on the 1 MHz clock (1 tick = 1 us).
// Fires a TRIG_US trigger every PERIOD_US cycles while enabled, times the
// synchronised echo and publishes whole centimetres as (w*1130)>>16 (about w/58).
// Build option SONAR_AVG_EN: report the mean of the last four valid distances
// instead of the raw value; dist_vld then arrives one cycle later.
module sonar_ranger #(
    parameter int TRIG_US    = 10,
    parameter int PERIOD_US  = 60000,
    parameter int TIMEOUT_US = 38000,
    parameter int CNT_W      = 16
) (
    input  logic           clk_1m,
    input  logic           rst,
    sonar_ranger_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        CALC,
        HOLD
    } state_t;

    // The period counter already reads 0 in the first TRIG cycle, and the
    // IDLE cycle before TRIG is part of the period, so HOLD releases one
    // count early to land trigger rises exactly PERIOD_US apart.
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PERIOD_US - 2);
    localparam logic [CNT_W-1:0] WAIT_LAST    = CNT_W'(TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0] WIDTH_LIMIT  = CNT_W'(TIMEOUT_US);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [26:0]      CM_SCALE     = 27'd1130;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] echo_cnt_q, echo_cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             sync1_q, echo_s_q, echo_prev_q;
    logic             echo_rise, echo_fall;
    logic             s1_trig_q, busy_q;
    logic             timeout_q, timeout_d;
    logic             calc_go;
    logic [9:0]       dist_cm_q, dist_cm_d;
    logic             dist_vld_q, dist_vld_d;
    logic [26:0]      cm_prod;
    logic [9:0]       raw_cm;
    logic             unused_prod_bits;

    // Two-flop synchroniser for the raw echo, plus one more stage for edges.
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            sync1_q     <= bus.s1_echo;
            echo_s_q    <= sync1_q;
            echo_prev_q <= echo_s_q;
        end
    end

    assign echo_rise = echo_s_q & ~echo_prev_q;
    assign echo_fall = ~echo_s_q & echo_prev_q;

    // Next state, counters and the timeout pulse.
    always_comb begin
        state_d    = state_q;
        period_d   = (period_q == CNT_MAX) ? period_q : period_q + 1'b1;
        echo_cnt_d = echo_cnt_q;
        width_d    = width_q;
        timeout_d  = 1'b0;
        calc_go    = 1'b0;
        unique case (state_q)
            IDLE: begin
                period_d = period_q;
                if (bus.en) begin
                    state_d  = TRIG;
                    period_d = '0;
                end
            end
            TRIG: begin
                if (period_q == TRIG_LAST) begin
                    state_d    = WAIT_RISE;
                    echo_cnt_d = '0;
                end
            end
            WAIT_RISE: begin
                echo_cnt_d = echo_cnt_q + 1'b1;
                if (echo_rise) begin
                    // The cycle showing the rise already has echo high, so
                    // the width count restarts at one rather than zero.
                    state_d    = MEASURE;
                    echo_cnt_d = CNT_W'(1);
                end else if (echo_cnt_q == WAIT_LAST) begin
                    state_d   = HOLD;
                    timeout_d = 1'b1;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_d = CALC;
                    width_d = echo_cnt_q;
                end else if (echo_cnt_q == WIDTH_LIMIT) begin
                    state_d   = HOLD;
                    timeout_d = 1'b1;
                end else if (echo_s_q) begin
                    echo_cnt_d = echo_cnt_q + 1'b1;
                end
            end
            CALC: begin
                calc_go = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                // >= covers measurements that overran the period; the
                // counter saturates instead of wrapping in that case.
                if (period_q >= HOLD_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered control outputs.
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            state_q    <= IDLE;
            period_q   <= '0;
            echo_cnt_q <= '0;
            width_q    <= '0;
            s1_trig_q  <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            echo_cnt_q <= echo_cnt_d;
            width_q    <= width_d;
            s1_trig_q  <= (state_d == TRIG);
            busy_q     <= (state_d != IDLE);
            timeout_q  <= timeout_d;
        end
    end

    // Centimetres = floor(w * 1130 / 65536); at most 655, so no saturation.
    assign cm_prod          = 27'(width_q) * CM_SCALE;
    assign raw_cm           = cm_prod[25:16];
    assign unused_prod_bits = ^{cm_prod[26], cm_prod[15:0]};

`ifdef SONAR_AVG_EN
    logic [3:0][9:0] hist_q, hist_d;
    logic [11:0]     sum_q, sum_d;
    logic            primed_q, primed_d;
    logic            avg_pend_q;
    logic            unused_sum_bits;

    assign unused_sum_bits = ^sum_q[1:0];

    // Running four-sample sum; the first sample after reset fills all slots.
    always_comb begin
        hist_d     = hist_q;
        sum_d      = sum_q;
        primed_d   = primed_q;
        dist_cm_d  = dist_cm_q;
        dist_vld_d = avg_pend_q;
        if (calc_go) begin
            primed_d = 1'b1;
            if (!primed_q) begin
                hist_d = {4{raw_cm}};
                sum_d  = {raw_cm, 2'b00};
            end else begin
                hist_d = {hist_q[2:0], raw_cm};
                sum_d  = sum_q - {2'b00, hist_q[3]} + {2'b00, raw_cm};
            end
        end
        if (avg_pend_q) begin
            dist_cm_d = sum_q[11:2];
        end
    end

    // History registers; the mean is published one cycle after CALC.
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            hist_q     <= '0;
            sum_q      <= '0;
            primed_q   <= 1'b0;
            avg_pend_q <= 1'b0;
        end else begin
            hist_q     <= hist_d;
            sum_q      <= sum_d;
            primed_q   <= primed_d;
            avg_pend_q <= calc_go;
        end
    end
`else
    // Raw result is published straight out of CALC.
    always_comb begin
        dist_cm_d  = calc_go ? raw_cm : dist_cm_q;
        dist_vld_d = calc_go;
    end
`endif

    // Published distance and its strobe.
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            dist_cm_q  <= '0;
            dist_vld_q <= 1'b0;
        end else begin
            dist_cm_q  <= dist_cm_d;
            dist_vld_q <= dist_vld_d;
        end
    end

    assign bus.s1_trig  = s1_trig_q;
    assign bus.busy     = busy_q;
    assign bus.timeout  = timeout_q;
    assign bus.dist_cm  = dist_cm_q;
    assign bus.dist_vld = dist_vld_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: directed table, reset corner cases and randomised echoes
// for sonar_ranger, checked against a behavioural distance model.
// Shortened period/timeout keep the run small while preserving all rules.
module tb_sonar_ranger;

    localparam int TRIG_US    = 10;
    localparam int PERIOD_US  = 6100;
    localparam int TIMEOUT_US = 5850;
`ifdef SONAR_AVG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    typedef struct {
        int delay;
        int width;
        bit pre_high;
        bit exp_to;
        int exp_cm;
    } vec_t;

    logic clk_1m = 1'b0;
    logic rst    = 1'b1;

    sonar_ranger_if bus();

    sonar_ranger #(
        .TRIG_US   (TRIG_US),
        .PERIOD_US (PERIOD_US),
        .TIMEOUT_US(TIMEOUT_US),
        .CNT_W     (16)
    ) dut (
        .clk_1m(clk_1m),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_1m = ~clk_1m;

    int cyc = 0;
    always @(posedge clk_1m) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Event recorder for the strobes.
    int vld_cyc[$];
    int vld_val[$];
    int to_cyc[$];
    always @(negedge clk_1m) begin
        if (bus.dist_vld) begin
            vld_cyc.push_back(cyc);
            vld_val.push_back(int'(bus.dist_cm));
        end
        if (bus.timeout) to_cyc.push_back(cyc);
        if (bus.dist_vld || bus.timeout)
            check("vld_timeout_exclusive", int'(bus.dist_vld & bus.timeout), 0);
    end

    // Reference model: distance = floor(width_us * 1130 / 65536).
    int model_hist[$];
    int exp_dist = 0;

    function automatic int cm_of(input int w);
        return (w * 1130) / 65536;
    endfunction

    task automatic model_valid(input int raw);
`ifdef SONAR_AVG_EN
        int s;
        if (model_hist.size() == 0) begin
            repeat (4) model_hist.push_back(raw);
        end else begin
            void'(model_hist.pop_front());
            model_hist.push_back(raw);
        end
        s = 0;
        foreach (model_hist[k]) s += model_hist[k];
        exp_dist = s / 4;
`else
        exp_dist = raw;
`endif
    endtask

    task automatic model_reset();
        model_hist.delete();
        exp_dist = 0;
    endtask

    task automatic wait_trig(input logic level, input int budget, output int at, output bit ok);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_1m);
            if (bus.s1_trig === level) begin
                ok = 1'b1;
                at = cyc;
            end
        end
    endtask

    int prev_rise = -1;

    task automatic run_meas(input string tag, input int delay, input int width, input bit pre_high,
                            input bit exp_to, input int exp_raw, output int r);
        int  f;
        int  rise_drv;
        int  fall_drv;
        int  end_cyc;
        bit  ok;
        rise_drv = 0;
        wait_trig(1'b1, PERIOD_US + 50, r, ok);
        check($sformatf("%s_trig_seen", tag), int'(ok), 1);
        if (!ok) return;
        if (prev_rise >= 0) check($sformatf("%s_period", tag), r - prev_rise, PERIOD_US);
        prev_rise = r;
        vld_cyc.delete();
        vld_val.delete();
        to_cyc.delete();
        check($sformatf("%s_busy", tag), int'(bus.busy), 1);
        if (pre_high) bus.s1_echo = 1'b1;
        wait_trig(1'b0, TRIG_US + 5, f, ok);
        check($sformatf("%s_trig_width", tag), f - r, TRIG_US);
        if (!ok) return;
        if (pre_high) begin
            repeat (width) @(negedge clk_1m);
            bus.s1_echo = 1'b0;
            fall_drv = cyc;
        end else if (width > 0) begin
            repeat (delay) @(negedge clk_1m);
            bus.s1_echo = 1'b1;
            rise_drv = cyc;
            repeat (width) @(negedge clk_1m);
            bus.s1_echo = 1'b0;
            fall_drv = cyc;
        end else begin
            fall_drv = f;
        end
        end_cyc = (fall_drv + LAT + 4 > f + TIMEOUT_US + 6) ? fall_drv + LAT + 4 : f + TIMEOUT_US + 6;
        while (cyc < end_cyc) @(negedge clk_1m);
        if (exp_to) begin
            check($sformatf("%s_timeout_count", tag), to_cyc.size(), 1);
            check($sformatf("%s_vld_count", tag), vld_cyc.size(), 0);
            if (to_cyc.size() == 1) begin
                if (width == 0 || pre_high)
                    check($sformatf("%s_timeout_time", tag), to_cyc[0] - f, TIMEOUT_US);
                else
                    check($sformatf("%s_timeout_window", tag),
                          int'(to_cyc[0] >= rise_drv + TIMEOUT_US && to_cyc[0] <= rise_drv + TIMEOUT_US + 4), 1);
            end
        end else begin
            model_valid(exp_raw);
            check($sformatf("%s_vld_count", tag), vld_cyc.size(), 1);
            check($sformatf("%s_timeout_count", tag), to_cyc.size(), 0);
            if (vld_cyc.size() == 1) begin
                check($sformatf("%s_latency", tag), vld_cyc[0] - fall_drv, LAT);
                check($sformatf("%s_vld_dist", tag), vld_val[0], exp_dist);
            end
        end
        check($sformatf("%s_dist_held", tag), int'(bus.dist_cm), exp_dist);
    endtask

    // Hard stop in case something upstream wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   r;
        int   rel;
        int   d;
        int   w;
        int   dummy;
        bit   ok;

        tbl[0] = '{delay: 100, width: 580,  pre_high: 1'b0, exp_to: 1'b0, exp_cm: 10};
        tbl[1] = '{delay: 100, width: 58,   pre_high: 1'b0, exp_to: 1'b0, exp_cm: 1};
        tbl[2] = '{delay: 100, width: 57,   pre_high: 1'b0, exp_to: 1'b0, exp_cm: 0};
        tbl[3] = '{delay: 100, width: 0,    pre_high: 1'b0, exp_to: 1'b1, exp_cm: 0};
        tbl[4] = '{delay: 100, width: 5900, pre_high: 1'b0, exp_to: 1'b1, exp_cm: 0};
        tbl[5] = '{delay: 0,   width: 3000, pre_high: 1'b1, exp_to: 1'b1, exp_cm: 0};
        tbl[6] = '{delay: 100, width: 5800, pre_high: 1'b0, exp_to: 1'b0, exp_cm: 100};

        bus.en      = 1'b1;
        bus.s1_echo = 1'b0;
        rst         = 1'b1;
        repeat (5) begin
            @(negedge clk_1m);
            check("reset_outputs",
                  int'({bus.s1_trig, bus.busy, bus.dist_vld, bus.timeout, bus.dist_cm}), 0);
        end
        rst = 1'b0;
        rel = cyc;

        for (int i = 0; i < 7; i++) begin
            run_meas($sformatf("vec%0d", i), tbl[i].delay, tbl[i].width, tbl[i].pre_high,
                     tbl[i].exp_to, tbl[i].exp_cm, r);
            if (i == 0) check("trig_after_reset", r - rel, 1);
        end

        // Reset while an echo is being measured.
        wait_trig(1'b1, PERIOD_US + 50, dummy, ok);
        check("rstmid_trig_seen", int'(ok), 1);
        wait_trig(1'b0, TRIG_US + 5, dummy, ok);
        repeat (100) @(negedge clk_1m);
        bus.s1_echo = 1'b1;
        repeat (200) @(negedge clk_1m);
        check("rstmid_dist_before", int'(bus.dist_cm), exp_dist);
        vld_cyc.delete();
        to_cyc.delete();
        rst = 1'b1;
        @(negedge clk_1m);
        model_reset();
        check("rstmid_trig", int'(bus.s1_trig), 0);
        check("rstmid_busy", int'(bus.busy), 0);
        check("rstmid_dist", int'(bus.dist_cm), exp_dist);
        bus.s1_echo = 1'b0;
        repeat (2) @(negedge clk_1m);
        check("rstmid_no_vld", vld_cyc.size(), 0);
        rst = 1'b0;
        prev_rise = -1;

        // Randomised echoes against the model.
        for (int i = 0; i < 3; i++) begin
            d = int'($urandom_range(5, 300));
            w = int'($urandom_range(1, 5500));
            run_meas($sformatf("rand%0d_w%0d", i, w), d, w, 1'b0, 1'b0, cm_of(w), r);
        end

        // en dropped: the cycle already running finishes, then no new trigger.
        bus.en = 1'b0;
        wait_trig(1'b1, PERIOD_US + 20, dummy, ok);
        check("en_off_no_trig", int'(ok), 0);
        check("en_off_busy", int'(bus.busy), 0);
        check("en_off_dist", int'(bus.dist_cm), exp_dist);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
